// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundle of the three requester ports (I fetch, D data, X loader) and the
//   single-port RAM side of the memory arbiter.
//   Requesters: *_req, *_addr, *_we, *_wdata, x_lock in; *_gnt, *_rvalid, *_rdata out.
//   RAM side:   mem_en, mem_we, mem_addr, mem_wdata out; mem_rdata in.
//   slave modport  : arbiter view.
//   master modport : environment view (requesters plus RAM model).
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          x_req;
    logic          x_we;
    logic          x_lock;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic          x_gnt;
    logic          x_rvalid;
    logic [DW-1:0] x_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  x_req, x_we, x_lock, x_addr, x_wdata,
        input  mem_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output x_gnt, x_rvalid, x_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output x_req, x_we, x_lock, x_addr, x_wdata,
        output mem_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  x_gnt, x_rvalid, x_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one synchronous single-port RAM between the instruction-fetch (I),
//   data (D) and loader/debug (X) ports. One grant per cycle, base priority
//   D > I > X, with starvation aging: a port denied STARVE_LIMIT consecutive
//   cycles is promoted above base priority. X may lock the RAM for a burst.
//   Read data returns one cycle after the grant, tagged to the granted port.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mem_arbiter_if.slave (requester ports and RAM side)
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t        state_q;
    logic [3:0]    cnt_dport_q, cnt_iport_q, cnt_xport_q;
    logic [3:0]    cnt_dport_d, cnt_iport_d, cnt_xport_d;
    logic          rv_i_q, rv_d_q, rv_x_q;
    logic [DW-1:0] hold_i_q, hold_d_q, hold_x_q;
    logic          gnt_i, gnt_d, gnt_x;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    function automatic logic [3:0] cnt_next(input logic [3:0] c, input logic req,
                                            input logic gnt);
        if (req && !gnt) return (c >= LIM) ? LIM : c + 4'd1;
        return 4'd0;
    endfunction

    // Grant: starved ports first (in base order), then base order D > I > X.
    // While locked, only the loader can be served. Nothing is granted in reset.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        gnt_x = 1'b0;
        if (rst_n) begin
            if (state_q == LOCKED)                      gnt_x = bus.x_req;
            else if (bus.d_req && cnt_dport_q == LIM)   gnt_d = 1'b1;
            else if (bus.i_req && cnt_iport_q == LIM)   gnt_i = 1'b1;
            else if (bus.x_req && cnt_xport_q == LIM)   gnt_x = 1'b1;
            else if (bus.d_req)                         gnt_d = 1'b1;
            else if (bus.i_req)                         gnt_i = 1'b1;
            else if (bus.x_req)                         gnt_x = 1'b1;
        end
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (gnt_d) begin
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
        end else if (gnt_i) begin
            addr_mux  = bus.i_addr;
        end else if (gnt_x) begin
            addr_mux  = bus.x_addr;
            wdata_mux = bus.x_wdata;
        end
    end

    always_comb begin
        cnt_dport_d = cnt_next(cnt_dport_q, bus.d_req, gnt_d);
        cnt_iport_d = cnt_next(cnt_iport_q, bus.i_req, gnt_i);
        cnt_xport_d = cnt_next(cnt_xport_q, bus.x_req, gnt_x);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            cnt_dport_q <= '0;
            cnt_iport_q <= '0;
            cnt_xport_q <= '0;
            rv_i_q      <= 1'b0;
            rv_d_q      <= 1'b0;
            rv_x_q      <= 1'b0;
            hold_i_q    <= '0;
            hold_d_q    <= '0;
            hold_x_q    <= '0;
        end else begin
            case (state_q)
                ARB:     if (gnt_x && bus.x_lock) state_q <= LOCKED;
                LOCKED:  if ((bus.x_req && gnt_x && !bus.x_lock) ||
                             (!bus.x_req && !bus.x_lock)) state_q <= ARB;
                default: state_q <= ARB;
            endcase
            cnt_dport_q <= cnt_dport_d;
            cnt_iport_q <= cnt_iport_d;
            cnt_xport_q <= cnt_xport_d;
            // Owner/is_read of this cycle's grant, one flag per port.
            rv_i_q <= gnt_i;
            rv_d_q <= gnt_d & ~bus.d_we;
            rv_x_q <= gnt_x & ~bus.x_we;
            // Keep the last returned word so rdata holds between responses.
            if (rv_i_q) hold_i_q <= bus.mem_rdata;
            if (rv_d_q) hold_d_q <= bus.mem_rdata;
            if (rv_x_q) hold_x_q <= bus.mem_rdata;
        end
    end

    assign bus.i_gnt     = gnt_i;
    assign bus.d_gnt     = gnt_d;
    assign bus.x_gnt     = gnt_x;
    assign bus.mem_en    = gnt_i | gnt_d | gnt_x;
    assign bus.mem_we    = (gnt_d & bus.d_we) | (gnt_x & bus.x_we);
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    // RAM read data is only valid in the response cycle; pass it straight
    // through then, otherwise present the held value.
    assign bus.i_rvalid = rv_i_q;
    assign bus.d_rvalid = rv_d_q;
    assign bus.x_rvalid = rv_x_q;
    assign bus.i_rdata  = rv_i_q ? bus.mem_rdata : hold_i_q;
    assign bus.d_rdata  = rv_d_q ? bus.mem_rdata : hold_d_q;
    assign bus.x_rdata  = rv_x_q ? bus.mem_rdata : hold_x_q;
endmodule
